rtc_bus_sequencer: RTL

Sequences single read and write transactions on the RTC's multiplexed 8-bit address/data bus. Generates the chip-select, address/data-select, read and write strobes with programmable phase widths. Drives the data bus through the output tri-state buffer via `bus_oe`/`bus_out` and captures read data from the bus.

---
 rtl/rtc_bus_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: single read/write transactions on the RTC multiplexed address/data bus.
// Define RTC_SEQ_QUEUE_EN to add a one-entry pending-request slot filled while busy.
module rtc_bus_sequencer #(
  parameter int PHASE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_write,
  input  logic       req_read,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(PHASE_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, A_SET, A_STB, A_HOLD, D_SET, D_STB, D_HOLD, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic req_v_q, req_w_q, dir_q, dir_d, slot_v_q, slot_v_d, slot_w_q, slot_w_d;
  logic [7:0] req_a_q, req_d_q, addr_q, addr_d, wdata_q, wdata_d, slot_a_q, slot_a_d, slot_d_q, slot_d_d;
  logic [7:0] bus_out_d, rdata_d;
  logic bus_oe_d, cs_n_d, ad_n_d, wr_n_d, rd_n_d, busy_d, done_d, last, a_ph, d_ph;
  always_comb begin
    last = cnt_q == CW'(PHASE_CYCLES - 1);
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    dir_d = dir_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    slot_v_d = slot_v_q;
    slot_w_d = slot_w_q;
    slot_a_d = slot_a_q;
    slot_d_d = slot_d_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (req_v_q) begin
        state_d = A_SET;
        dir_d = req_w_q;
        addr_d = req_a_q;
        wdata_d = req_d_q;
      end
    end else if (state_q == DONE) begin
      cnt_d = '0;
      state_d = IDLE;
`ifdef RTC_SEQ_QUEUE_EN
      // A request landing in DONE with an empty slot is treated as if it filled the slot.
      if (slot_v_q || req_v_q) begin
        state_d = A_SET;
        dir_d = slot_v_q ? slot_w_q : req_w_q;
        addr_d = slot_v_q ? slot_a_q : req_a_q;
        wdata_d = slot_v_q ? slot_d_q : req_d_q;
        slot_v_d = 1'b0;
      end
`endif
    end else if (last) begin
      cnt_d = '0;
      state_d = state_t'(state_q + 3'd1);
    end
`ifdef RTC_SEQ_QUEUE_EN
    if (state_q != IDLE && state_q != DONE && req_v_q && !slot_v_q) begin
      slot_v_d = 1'b1;
      slot_w_d = req_w_q;
      slot_a_d = req_a_q;
      slot_d_d = req_d_q;
    end
`endif
    // Outputs are decoded from the next state so the registered pins line up with the state.
    a_ph = state_d inside {A_SET, A_STB, A_HOLD};
    d_ph = state_d inside {D_SET, D_STB, D_HOLD};
    cs_n_d = !(a_ph || d_ph);
    ad_n_d = !a_ph;
    bus_oe_d = a_ph || (d_ph && dir_d);
    bus_out_d = a_ph ? addr_d : (d_ph && dir_d) ? wdata_d : 8'h00;
    wr_n_d = !(state_d == A_STB || (state_d == D_STB && dir_d));
    rd_n_d = !(state_d == D_STB && !dir_d);
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
    rdata_d = (state_q == D_STB && last) ? bus_in : rdata;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      req_v_q <= 1'b0;
      req_w_q <= 1'b0;
      req_a_q <= '0;
      req_d_q <= '0;
      dir_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      slot_v_q <= 1'b0;
      slot_w_q <= 1'b0;
      slot_a_q <= '0;
      slot_d_q <= '0;
      bus_out <= '0;
      bus_oe <= 1'b0;
      cs_n <= 1'b1;
      ad_n <= 1'b1;
      wr_n <= 1'b1;
      rd_n <= 1'b1;
      rdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      req_v_q <= req_write || req_read;
      req_w_q <= req_write;
      req_a_q <= addr;
      req_d_q <= wdata;
      dir_q <= dir_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      slot_v_q <= slot_v_d;
      slot_w_q <= slot_w_d;
      slot_a_q <= slot_a_d;
      slot_d_q <= slot_d_d;
      bus_out <= bus_out_d;
      bus_oe <= bus_oe_d;
      cs_n <= cs_n_d;
      ad_n <= ad_n_d;
      wr_n <= wr_n_d;
      rd_n <= rd_n_d;
      rdata <= rdata_d;
      busy <= busy_d;
      done <= done_d;
    end
  end
endmodule
